// File: rtl/ov5640_pkg.sv
// Shared state encodings and default timing constants for the OV5640 power sequencer.
package ov5640_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWDN_HOLD = 3'd1,
        ST_RST_HOLD  = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_DONE      = 3'd4,
        ST_FAIL      = 3'd5
    } seq_st_t;

    localparam int DEF_CNT_6MS   = 300_000;
    localparam int DEF_CNT_2MS   = 100_000;
    localparam int DEF_CNT_21MS  = 1_050_000;
    localparam int DEF_CNT_TO    = 50_000_000;
    localparam int DEF_MAX_RETRY = 3;

    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ov5640_dly_cnt.sv
// Clear/enable up-counter with a terminal-compare flag; used for phase timing and the watchdog.
module ov5640_dly_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_hit
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_hit = (r_cnt == i_term);

endmodule

// File: rtl/ov5640_power_seq.sv
// OV5640 PWDN/RESETB power-up sequencer with re-power on request.
// Define OV5640_CFG_WDT_EN to add the cfg_done watchdog with bounded retries.
module ov5640_power_seq
    import ov5640_pkg::*;
#(
    parameter int CNT_6MS   = DEF_CNT_6MS,
    parameter int CNT_2MS   = DEF_CNT_2MS,
    parameter int CNT_21MS  = DEF_CNT_21MS,
    parameter int CNT_TO    = DEF_CNT_TO,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pwr_en,
    input  logic       restart,
    input  logic       cfg_done,
    output logic       ov5640_pwdn,
    output logic       ov5640_rst_n,
    output logic       power_done,
    output logic [2:0] seq_state,
    output logic       seq_fail
);

    localparam int CW = cnt_width(CNT_6MS, CNT_2MS, CNT_21MS, CNT_TO);
    localparam logic [CW-1:0] T_6MS  = CW'(CNT_6MS - 1);
    localparam logic [CW-1:0] T_2MS  = CW'(CNT_2MS - 1);
    localparam logic [CW-1:0] T_21MS = CW'(CNT_21MS - 1);

    seq_st_t       r_state;
    seq_st_t       w_next;
    logic          r_pwdn;
    logic          r_rst_n;
    logic          r_done;
    logic          w_restart;
    logic          w_en;
    logic          w_clr;
    logic          w_hit;
    logic [CW-1:0] w_term;

    assign w_restart = restart && (r_state != ST_IDLE);

    always_comb begin
        w_term = T_6MS;
        w_en   = 1'b0;
        unique case (r_state)
            ST_PWDN_HOLD: begin
                w_term = T_6MS;
                w_en   = pwr_en;
            end
            ST_RST_HOLD: begin
                w_term = T_2MS;
                w_en   = 1'b1;
            end
            ST_SETTLE: begin
                w_term = T_21MS;
                w_en   = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter restarts on every state change, including restart into PWDN_HOLD.
    assign w_clr = w_restart || (w_next != r_state);

    ov5640_dly_cnt #(
        .W (CW)
    ) u_phase_cnt (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_term (w_term),
        .o_hit  (w_hit)
    );

`ifdef OV5640_CFG_WDT_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);
    localparam logic [CW-1:0] T_TO  = CW'(CNT_TO - 1);

    logic [RW-1:0] r_retry;
    logic          r_fail;
    logic          w_wdt_en;
    logic          w_wdt_clr;
    logic          w_wdt_hit;
    logic          w_tout;

    assign w_wdt_en  = (r_state == ST_DONE) && !cfg_done;
    assign w_wdt_clr = w_restart || cfg_done || (w_next != ST_DONE);
    assign w_tout    = w_wdt_en && w_wdt_hit;

    ov5640_dly_cnt #(
        .W (CW)
    ) u_wdt_cnt (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .i_clr  (w_wdt_clr),
        .i_en   (w_wdt_en),
        .i_term (T_TO),
        .o_hit  (w_wdt_hit)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_retry <= '0;
            r_fail  <= 1'b0;
        end else begin
            if (w_restart) begin
                r_retry <= '0;
            end else if (w_tout && (r_retry != R_MAX)) begin
                r_retry <= r_retry + RW'(1);
            end
            r_fail <= (w_next == ST_FAIL);
        end
    end

    assign seq_fail = r_fail;
`else
    localparam int unused_max_retry = MAX_RETRY;
    logic w_unused_cfg;

    assign w_unused_cfg = cfg_done;
    assign seq_fail     = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        if (w_restart) begin
            w_next = ST_PWDN_HOLD;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (pwr_en) w_next = ST_PWDN_HOLD;
                end
                ST_PWDN_HOLD: begin
                    if (w_hit && w_en) w_next = ST_RST_HOLD;
                end
                ST_RST_HOLD: begin
                    if (w_hit) w_next = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_hit) w_next = ST_DONE;
                end
                ST_DONE: begin
`ifdef OV5640_CFG_WDT_EN
                    if (w_tout) begin
                        w_next = (r_retry == R_MAX) ? ST_FAIL : ST_PWDN_HOLD;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Pins are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_pwdn  <= 1'b1;
            r_rst_n <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pwdn  <= (w_next inside {ST_IDLE, ST_PWDN_HOLD, ST_FAIL});
            r_rst_n <= (w_next inside {ST_SETTLE, ST_DONE});
            r_done  <= (w_next == ST_DONE);
        end
    end

    assign ov5640_pwdn  = r_pwdn;
    assign ov5640_rst_n = r_rst_n;
    assign power_done   = r_done;
    assign seq_state    = r_state;

endmodule

// File: tb/tb_ov5640_power_seq.sv
// Self-checking bench for ov5640_power_seq: directed timing checks plus random stimulus vs a phase model.
// Define OV5640_CFG_WDT_EN to exercise the watchdog build.
module tb_ov5640_power_seq;

    localparam int P6   = 6;
    localparam int P2   = 2;
    localparam int P21  = 21;
    localparam int PTO  = 50;
    localparam int PMAX = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       pwr_en;
    logic       restart;
    logic       cfg_done;
    logic       ov5640_pwdn;
    logic       ov5640_rst_n;
    logic       power_done;
    logic [2:0] seq_state;
    logic       seq_fail;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    ov5640_power_seq #(
        .CNT_6MS   (P6),
        .CNT_2MS   (P2),
        .CNT_21MS  (P21),
        .CNT_TO    (PTO),
        .MAX_RETRY (PMAX)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .pwr_en       (pwr_en),
        .restart      (restart),
        .cfg_done     (cfg_done),
        .ov5640_pwdn  (ov5640_pwdn),
        .ov5640_rst_n (ov5640_rst_n),
        .power_done   (power_done),
        .seq_state    (seq_state),
        .seq_fail     (seq_fail)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Phase model: phase number, cycles spent in the phase, watchdog age, retries used.
    int m_ph = 0;
    int m_el = 0;
    int m_wd = 0;
    int m_retry = 0;
    int dur [1:3];
    logic [5:0] pwdn_tab = 6'b100011;
    logic [5:0] rstn_tab = 6'b011000;

    initial begin
        dur[1] = P6;
        dur[2] = P2;
        dur[3] = P21;
    end

    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            m_ph = 0; m_el = 0; m_wd = 0; m_retry = 0;
        end else if (restart && m_ph != 0) begin
            m_ph = 1; m_el = 0; m_wd = 0; m_retry = 0;
        end else begin
            case (m_ph)
                0: if (pwr_en) begin m_ph = 1; m_el = 0; end
                1, 2, 3: begin
                    if (m_ph != 1 || pwr_en) m_el++;
                    if (m_el == dur[m_ph]) begin
                        m_ph++; m_el = 0; m_wd = 0;
                    end
                end
                4: begin
`ifdef OV5640_CFG_WDT_EN
                    if (cfg_done) m_wd = 0;
                    else begin
                        m_wd++;
                        if (m_wd == PTO) begin
                            m_wd = 0;
                            if (m_retry < PMAX) begin
                                m_retry++; m_ph = 1; m_el = 0;
                            end else begin
                                m_ph = 5;
                            end
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    function automatic logic [6:0] dut_vec();
        return {seq_state, ov5640_pwdn, ov5640_rst_n, power_done, seq_fail};
    endfunction

    always @(negedge sys_clk) begin
        if (chk_on) begin
            check("cycle_outputs", 32'(dut_vec()),
                  32'({3'(m_ph), pwdn_tab[m_ph], rstn_tab[m_ph], m_ph == 4, m_ph == 5}));
        end
    end

    task automatic count_st(input logic [2:0] s, output int n);
        n = 0;
        while (seq_state === s && n < 200) begin
            n++;
            @(negedge sys_clk);
        end
    endtask

    task automatic wait_st(input string name, input logic [2:0] s, input int lim);
        int n = 0;
        while (seq_state !== s && n < lim) begin
            n++;
            @(negedge sys_clk);
        end
        check(name, 32'(seq_state), 32'(s));
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge sys_clk);
        restart = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a, b, c, n;
        sys_rst_n = 1'b0; pwr_en = 1'b0; restart = 1'b0; cfg_done = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_on = 1'b1;
        check("reset_vals", 32'(dut_vec()), 32'(7'b000_1_0_0_0));

        // Basic power-up timing
        sys_rst_n = 1'b1; pwr_en = 1'b1;
        @(negedge sys_clk);
        count_st(3'd1, a); check("t1_pwdn_cycles", a, 6);
        count_st(3'd2, b); check("t1_rst_cycles", b, 2);
        count_st(3'd3, c); check("t1_settle_cycles", c, 21);
        check("t1_done_latency", a + b + c, 29);
        check("t1_done_pins", 32'(dut_vec()), 32'(7'b100_0_1_1_0));

        // pwr_en pause inside PWDN_HOLD
        pulse_restart();
        check("t2_restart_state", 32'(seq_state), 1);
        n = 0;
        while (seq_state === 3'd1 && n < 100) begin
            n++;
            pwr_en = (n <= 3 || n >= 14);
            @(negedge sys_clk);
        end
        pwr_en = 1'b1;
        check("t2_pwdn_paused", n, 16);
        count_st(3'd2, b); check("t2_rst_cycles", b, 2);

        // Restart from SETTLE
        repeat (5) @(negedge sys_clk);
        pulse_restart();
        check("t3_restart_pins", 32'(dut_vec()), 32'(7'b001_1_0_0_0));
        count_st(3'd1, a); count_st(3'd2, b); count_st(3'd3, c);
        check("t3_done_latency", a + b + c, 29);
        check("t3_done", 32'(power_done), 1);

        // Restart coincident with RST_HOLD terminal count
        pulse_restart();
        wait_st("t4_reach_rst", 3'd2, 20);
        @(negedge sys_clk);
        pulse_restart();
        check("t4_restart_wins", 32'(seq_state), 1);

        // Reset mid SETTLE
        wait_st("t6_reach_settle", 3'd3, 20);
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check("t6_reset_pins", 32'(dut_vec()), 32'(7'b000_1_0_0_0));

        // Watchdog behaviour in DONE with cfg_done low
        cfg_done = 1'b0;
        wait_st("t5_reach_done", 3'd4, 40);
`ifdef OV5640_CFG_WDT_EN
        for (int r = 0; r < 3; r++) begin
            count_st(3'd4, n);
            check("t5_wdt_cycles", n, 50);
            if (r < 2) begin
                check("t5_repower", 32'(seq_state), 1);
                wait_st("t5_reach_done_again", 3'd4, 40);
            end else begin
                check("t5_fail_pins", 32'(dut_vec()), 32'(7'b101_1_0_0_1));
            end
        end
        repeat (20) @(negedge sys_clk);
        check("t5_fail_sticky", 32'(seq_state), 5);
        pulse_restart();
        check("t5_fail_cleared", 32'(seq_fail), 0);
        wait_st("t5_reach_done_cfg", 3'd4, 40);
        repeat (19) @(negedge sys_clk);
        cfg_done = 1'b1;
        repeat (100) @(negedge sys_clk);
        check("t5_cfg_no_retry", 32'(seq_state), 4);
`else
        repeat (100) @(negedge sys_clk);
        check("t5_no_wdt_hold", 32'(dut_vec()), 32'(7'b100_0_1_1_0));
`endif

        // Random stimulus against the phase model
        for (int i = 0; i < 4000; i++) begin
            pwr_en    = ($urandom_range(0, 3) != 0);
            restart   = ($urandom_range(0, 119) == 0);
            sys_rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 29) == 0) cfg_done = !cfg_done;
            @(negedge sys_clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
